// File: rtl/spi_slave_rx_if.sv
// Signal bundle between the SPI slave receiver and its surroundings: the 4-wire SPI
// pins plus the register-write and status side.
interface spi_slave_rx_if #(
    parameter int unsigned FRAME_BITS = 24
);
    logic                  spi_cs;
    logic                  spi_sck;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic [FRAME_BITS-1:0] tx_data;
    logic [FRAME_BITS-1:0] rx_data;
    logic                  rx_valid;
    logic                  wr_en;
    logic [3:0]            wr_addr;
    logic [15:0]           wr_data;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  spi_cs, spi_sck, spi_mosi, tx_data,
        output spi_miso, rx_data, rx_valid, wr_en, wr_addr, wr_data, frame_err, busy
    );

    modport master (
        output spi_cs, spi_sck, spi_mosi, tx_data,
        input  spi_miso, rx_data, rx_valid, wr_en, wr_addr, wr_data, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_rx.sv
// Oversampling SPI slave: decodes {cmd, addr, data} frames into a register-write strobe
// and shifts a reply word out on MISO. All logic runs in the sys_clk domain.
module spi_slave_rx #(
    parameter int unsigned FRAME_BITS  = 24,
    parameter logic [3:0]  WR_CMD      = 4'b1000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    spi_slave_rx_if.slave bus
);

    localparam int unsigned CntW = $clog2(FRAME_BITS + 2);
    localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);
    localparam logic [CntW-1:0] CntMax  = CntW'(FRAME_BITS + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone, StWaitCs} state_e;

    logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, mosi_sync_q;
    logic                   cs_dly_q, sck_dly_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   cs_s, sck_s, mosi_s, sync_ok;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]  tx_shift_q, rx_shift_q, rx_data_q;
    logic [CntW-1:0]        bit_cnt_q;
    logic                   busy_q, rx_valid_q, wr_en_q, frame_err_q;
    logic [3:0]             wr_addr_q;
    logic [15:0]            wr_data_q;

    logic start, sample, tx_shift_en, commit, err, done, is_wr;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cs_sync_q   <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_dly_q    <= 1'b1;
            sck_dly_q   <= 1'b0;
            fill_q      <= '0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
            cs_dly_q    <= cs_s;
            sck_dly_q   <= sck_s;
            fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Edges are masked until the pipeline holds real pin values, so a CS held low through
    // reset is seen as a level (WAIT_CS) rather than a fresh falling edge.
    assign sync_ok  = fill_q[SYNC_STAGES];
    assign cs_fall  = sync_ok & cs_dly_q & ~cs_s;
    assign cs_rise  = sync_ok & ~cs_dly_q & cs_s;
    assign sck_rise = sync_ok & ~sck_dly_q & sck_s;
    assign sck_fall = sync_ok & sck_dly_q & ~sck_s;

    always_comb begin
        state_d     = state_q;
        start       = 1'b0;
        sample      = 1'b0;
        tx_shift_en = 1'b0;
        commit      = 1'b0;
        err         = 1'b0;
        done        = 1'b0;
        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    start   = 1'b1;
                    state_d = StShift;
                end else if (sync_ok && !cs_s) begin
                    state_d = StWaitCs;
                end
            end
            StShift: begin
                sample      = sck_fall;
                // The first rising edge keeps bit 23 on MISO for the master's first sample.
                tx_shift_en = sck_rise && (bit_cnt_q != '0);
                if (cs_rise) state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                commit  = (bit_cnt_q == CntFull);
                err     = (bit_cnt_q != CntFull);
                state_d = StIdle;
            end
            StWaitCs: begin
                if (cs_rise) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign is_wr = (rx_shift_q[FRAME_BITS-1 -: 4] == WR_CMD);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            bit_cnt_q   <= '0;
            busy_q      <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            if (start) begin
                tx_shift_q <= bus.tx_data;
                rx_shift_q <= '0;
                bit_cnt_q  <= '0;
                busy_q     <= 1'b1;
            end else begin
                if (sample) begin
                    rx_shift_q <= {rx_shift_q[FRAME_BITS-2:0], mosi_s};
                    if (bit_cnt_q != CntMax) bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                if (tx_shift_en) tx_shift_q <= {tx_shift_q[FRAME_BITS-2:0], 1'b0};
                if (done) busy_q <= 1'b0;
            end
            rx_valid_q  <= commit;
            wr_en_q     <= commit & is_wr;
            frame_err_q <= err;
            if (commit) rx_data_q <= rx_shift_q;
            if (commit && is_wr) begin
                wr_addr_q <= rx_shift_q[FRAME_BITS-5 -: 4];
                wr_data_q <= rx_shift_q[15:0];
            end
        end
    end

    assign bus.spi_miso  = (state_q == StShift) & tx_shift_q[FRAME_BITS-1];
    assign bus.rx_data   = rx_data_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Bench for spi_slave_rx: directed frames then random frames, each scored against
// a frame-level model of what the slave should report.
module tb_spi_slave_rx;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    spi_slave_rx_if #(.FRAME_BITS(24)) bus ();

    spi_slave_rx #(
        .FRAME_BITS (24),
        .WR_CMD     (4'b1000),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus)
    );

    always #10 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    logic [23:0] rx_seen[$];
    logic [19:0] wr_seen[$];
    int          err_seen;
    logic [23:0] last_rx;

    always @(negedge sys_clk) begin
        if (bus.rx_valid)  rx_seen.push_back(bus.rx_data);
        if (bus.wr_en)     wr_seen.push_back({bus.wr_addr, bus.wr_data});
        if (bus.frame_err) err_seen++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check(tag, {bus.spi_miso, bus.rx_data, bus.rx_valid, bus.wr_en, bus.wr_addr,
                    bus.wr_data, bus.frame_err, bus.busy}, 64'd0);
    endtask

    // Sends n bits of 'bits' MSB first; rst_at >= 0 pulses reset before that bit.
    task automatic run_frame(input logic [31:0] bits, input int n, input logic [23:0] tx,
                             input int rst_at);
        logic [31:0] miso_got, miso_exp;
        bit          active;
        int          lat;
        logic [23:0] word;
        active   = 1'b1;
        miso_got = '0;
        miso_exp = '0;
        rx_seen.delete();
        wr_seen.delete();
        err_seen = 0;

        bus.tx_data = tx;
        bus.spi_cs  = 1'b0;
        tick(8);
        check("busy_mid", 64'(bus.busy), 64'd1);
        bus.tx_data = 24'($urandom);

        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                sys_rst_n = 1'b0;
                #2;
                check_outputs_zero("reset_outputs");
                tick(2);
                sys_rst_n = 1'b1;
                active    = 1'b0;
                last_rx   = '0;
                tick(4);
            end
            bus.spi_mosi = bits[n-1-i];
            bus.spi_sck  = 1'b1;
            tick(6);
            miso_got    = {miso_got[30:0], bus.spi_miso};
            miso_exp    = {miso_exp[30:0], (i < 24) ? tx[23-i] : 1'b0};
            bus.spi_sck = 1'b0;
            tick(6);
        end
        bus.spi_mosi = 1'b0;
        tick(3);
        if (active) check("miso_bits", 64'(miso_got), 64'(miso_exp));

        bus.spi_cs = 1'b1;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            tick(1);
            if (lat == 0 && (bus.rx_valid || bus.frame_err)) lat = c;
        end
        check("miso_idle", 64'(bus.spi_miso), 64'd0);
        check("busy_end", 64'(bus.busy), 64'd0);

        word = bits[23:0];
        if (!active) begin
            check("rx_count", 64'(rx_seen.size()), 64'd0);
            check("err_count", 64'(err_seen), 64'd0);
            check("wr_count", 64'(wr_seen.size()), 64'd0);
        end else begin
            check("latency", 64'(lat), 64'd4);
            if (n == 24) begin
                check("rx_count", 64'(rx_seen.size()), 64'd1);
                if (rx_seen.size() > 0) check("rx_value", 64'(rx_seen[0]), 64'(word));
                check("err_count", 64'(err_seen), 64'd0);
                if (word[23:20] == 4'b1000) begin
                    check("wr_count", 64'(wr_seen.size()), 64'd1);
                    if (wr_seen.size() > 0) check("wr_value", 64'(wr_seen[0]), 64'(word[19:0]));
                end else begin
                    check("wr_count", 64'(wr_seen.size()), 64'd0);
                end
                last_rx = word;
            end else begin
                check("err_count", 64'(err_seen), 64'd1);
                check("rx_count", 64'(rx_seen.size()), 64'd0);
                check("wr_count", 64'(wr_seen.size()), 64'd0);
            end
        end
        check("rx_data_hold", 64'(bus.rx_data), 64'(last_rx));
    endtask

    initial begin
        int          n;
        logic [31:0] bits;
        sys_rst_n    = 1'b0;
        bus.spi_cs   = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.tx_data  = '0;
        last_rx      = '0;
        err_seen     = 0;
        tick(3);
        check_outputs_zero("reset_state");
        sys_rst_n = 1'b1;
        tick(6);
        check_outputs_zero("idle_after_reset");

        run_frame(32'h008A1234, 24, 24'h5A5A5A, -1);
        run_frame(32'h0035BEEF, 24, 24'h0F0F0F, -1);
        run_frame(32'h00123456, 24, 24'hC3A55A, -1);
        run_frame(32'h000ABCDE, 20, 24'hFFFFFF, -1);
        run_frame(32'h03FFFFFF, 26, 24'h800001, -1);
        run_frame(32'h00810001, 24, 24'h000000, -1);
        run_frame(32'h0082FFFF, 24, 24'hAAAAAA, -1);
        run_frame(32'h00812345, 24, 24'h123456, 10);
        run_frame(32'h008F00FF, 24, 24'h654321, -1);

        for (int k = 0; k < 20; k++) begin
            n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : 24;
            bits = $urandom;
            if ($urandom_range(0, 1) == 1) bits[23:20] = 4'b1000;
            run_frame(bits, n, 24'($urandom), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
